// File: rtl/i2s_adc_receiver_pkg.sv
// Shared audio definitions for the I2S ADC receive path: frame-tracking
// states, default word width and LRCK channel encoding.
package i2s_adc_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } i2s_state_e;

    localparam int   SAMPLE_WIDTH_DEF = 16;

    // LRCK level for each channel: low = left, high = right
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous codec clock pin, with a third
// flop to derive single-cycle rise and fall strobes in the clk domain.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the pin and keep one cycle of history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: deserializes the codec's ADC stream (codec is clock
// master) into left/right sample pairs presented through a one-deep
// valid/ready output register in the clk domain.
module i2s_adc_receiver
    import i2s_adc_receiver_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int BITS_PER_CH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aud_bclk,
    input  logic                    aud_adclrck,
    input  logic                    aud_adcdat,
    input  logic                    enable,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int CNT_W = $clog2(BITS_PER_CH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_WIDTH);

    logic                    w_bclk_lvl_unused;
    logic                    w_bclk_rise;
    logic                    w_bclk_fall_unused;
    logic                    w_lr_sync;
    logic                    w_lr_rise;
    logic                    w_lr_fall;
    logic                    w_lr_edge;

    logic                    r_dat_meta;
    logic                    r_dat_sync;

    i2s_state_e              r_state;
    i2s_state_e              w_state_nxt;

    logic                    w_shift_en;
    logic                    w_word_done;
    logic                    w_frame_err;
    logic                    w_cnt_clr;
    logic [SAMPLE_WIDTH-1:0] w_word;

    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic [SAMPLE_WIDTH-1:0] r_right_hold;
    logic                    r_have_left;
    logic                    r_pair_pend;
    logic                    r_frame_err;

    logic [SAMPLE_WIDTH-1:0] r_left_sample;
    logic [SAMPLE_WIDTH-1:0] r_right_sample;
    logic                    r_sample_valid;
    logic                    r_overrun;

    sync_edge_detect u_bclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (aud_bclk),
        .o_sync  (w_bclk_lvl_unused),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_bclk_fall_unused)
    );

    sync_edge_detect u_lrck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (aud_adclrck),
        .o_sync  (w_lr_sync),
        .o_rise  (w_lr_rise),
        .o_fall  (w_lr_fall)
    );

    assign w_lr_edge = w_lr_rise | w_lr_fall;

    // The word including the bit arriving this cycle (MSB first, new bit at LSB)
    assign w_word = {r_shift, r_dat_sync};

    // Data pin needs only the two-flop synchronizer, no edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
        end else begin
            r_dat_meta <= aud_adcdat;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Frame-tracking state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any LRCK edge restarts the one-bit-delay skip for the new channel
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = w_lr_edge ? SKIP : IDLE;
                SKIP: begin
                    if (w_lr_edge) begin
                        w_state_nxt = SKIP;
                    end else if (w_bclk_rise) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = SKIP;
                    end
                end
                SHIFT: begin
                    if (w_lr_edge) begin
                        w_state_nxt = SKIP;
                    end else if (w_bclk_rise && (r_bit_cnt == LAST_BIT)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
                DONE:    w_state_nxt = w_lr_edge ? SKIP : DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Per-state datapath controls: counter clear, shift, word completion, framing error
    always_comb begin
        w_shift_en  = 1'b0;
        w_word_done = 1'b0;
        w_frame_err = 1'b0;
        w_cnt_clr   = 1'b0;
        if (!enable) begin
            w_shift_en  = 1'b0;
            w_word_done = 1'b0;
        end else begin
            case (r_state)
                SKIP: begin
                    if (!w_lr_edge && w_bclk_rise) begin
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_clr = 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_lr_edge) begin
                        w_frame_err = (r_bit_cnt < FULL_CNT);
                    end else if (w_bclk_rise) begin
                        w_shift_en  = 1'b1;
                        w_word_done = (r_bit_cnt == LAST_BIT);
                    end else begin
                        w_shift_en  = 1'b0;
                    end
                end
                IDLE, DONE: w_cnt_clr = 1'b0;
                default:    w_cnt_clr = 1'b0;
            endcase
        end
    end

    // Shift register, bit counter, per-channel holding registers and pair pairing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_have_left  <= 1'b0;
            r_pair_pend  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_pair_pend <= 1'b0;
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_shift_en) begin
                r_shift <= w_word[SAMPLE_WIDTH-2:0];
            end
            // A new period starts at the left edge; a truncated word breaks the pair
            if (!enable || w_lr_fall || w_frame_err) begin
                r_have_left <= 1'b0;
            end
            if (w_word_done) begin
                case (w_lr_sync)
                    CH_LEFT: begin
                        r_left_hold <= w_word;
                        r_have_left <= 1'b1;
                    end
                    CH_RIGHT: begin
                        r_right_hold <= w_word;
                        r_pair_pend  <= r_have_left;
                        r_have_left  <= 1'b0;
                    end
                    default: r_have_left <= 1'b0;
                endcase
            end
        end
    end

    // Output register: completed pairs always load; overrun flags an unconsumed pair being replaced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (enable) begin
            if (r_pair_pend) begin
                r_left_sample  <= r_left_hold;
                r_right_sample <= r_right_hold;
                r_sample_valid <= 1'b1;
                if (r_sample_valid && !sample_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_sample_valid && sample_ready) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    assign left_sample  = r_left_sample;
    assign right_sample = r_right_sample;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for i2s_adc_receiver: drives an I2S ADC stream at
// BCLK = clk/16 and compares delivered pairs and framing errors with a
// frame-level reference model.
module tb_i2s_adc_receiver;

    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aud_bclk = 1'b0;
    logic          aud_adclrck = 1'b0;
    logic          aud_adcdat = 1'b0;
    logic          enable = 1'b1;
    logic          sample_ready = 1'b1;
    logic [SW-1:0] left_sample;
    logic [SW-1:0] right_sample;
    logic          sample_valid;
    logic          overrun;
    logic          frame_err;

    int n_checks = 0;
    int n_errors = 0;

    // Observed traffic and reference-model expectations
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          obs_ferr = 0;
    int          exp_ferr = 0;
    int          ferr_run = 0;

    // Model state: last LRCK level the receiver has seen, whether the
    // current half began with an LRCK edge, its BCLK count, pending left word
    logic          m_prev_lr = 1'b0;
    bit            m_started = 1'b0;
    int            m_prev_n = 0;
    bit            m_left_ok = 1'b0;
    logic [SW-1:0] m_left_word = '0;

    always #5 clk = ~clk;

    i2s_adc_receiver #(.SAMPLE_WIDTH(SW), .BITS_PER_CH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .enable       (enable),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record accepted pairs and frame_err pulses, checking each pulse lasts one cycle
    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            obs_q.push_back({left_sample, right_sample});
        end
        if (frame_err === 1'b1) begin
            ferr_run++;
        end else begin
            if (ferr_run > 0) begin
                obs_ferr++;
                check_eq("frame_err_width", ferr_run, 1);
            end
            ferr_run = 0;
        end
    end

    task automatic model_reset();
        m_prev_lr = 1'b0;
        m_started = 1'b0;
        m_prev_n  = 0;
        m_left_ok = 1'b0;
    endtask

    // A channel change is an LRCK edge; it truncates a word still short of SW bits
    task automatic model_begin(input logic ch);
        if (ch != m_prev_lr) begin
            if (m_started && m_prev_n >= 1 && (m_prev_n - 1) < SW) exp_ferr++;
            m_started = 1'b1;
        end else begin
            m_started = 1'b0;
        end
        m_prev_lr = ch;
    endtask

    // A half yields a word when it began on an edge and had SW bits after the delay bit
    task automatic model_end(input logic ch, input int n, input logic [SW-1:0] word);
        bit complete;
        complete = m_started && ((n - 1) >= SW);
        m_prev_n = n;
        if (ch == 1'b0) begin
            m_left_ok   = complete;
            m_left_word = word;
        end else begin
            if (complete && m_left_ok) exp_q.push_back({m_left_word, word});
            m_left_ok = 1'b0;
        end
    endtask

    // One BCLK half-period (8 clk); optionally pulse sample_ready on a chosen cycle
    task automatic bclk_phase(input logic lvl, input logic lr, input logic d, input int pulse_at);
        @(posedge clk); #1;
        aud_bclk = lvl;
        if (!lvl) begin
            aud_adclrck = lr;
            aud_adcdat  = d;
        end
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (pulse_at > 0 && c == pulse_at)     sample_ready = 1'b1;
            if (pulse_at > 0 && c == pulse_at + 1) sample_ready = 1'b0;
        end
    endtask

    // One LRCK half: bit 0 is the I2S delay bit, bits 1..SW carry the word MSB first
    task automatic send_half(input logic ch, input int n, input logic [SW-1:0] word, input int pulse_bit);
        logic d;
        model_begin(ch);
        for (int i = 0; i < n; i++) begin
            if (i >= 1 && i <= SW) d = word[SW-i];
            else                   d = 1'($urandom);
            bclk_phase(1'b0, ch, d, 0);
            bclk_phase(1'b1, ch, d, (i == pulse_bit) ? 3 : 0);
        end
        model_end(ch, n, word);
    endtask

    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_half(1'b0, 32, l, -1);
        send_half(1'b1, 32, r, -1);
    endtask

    task automatic do_reset(input logic lr_level);
        aud_adclrck = lr_level;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
    endtask

    task automatic checkpoint(input string tag);
        int n;
        repeat (20) @(posedge clk);
        #1;
        check_eq({tag, "_npairs"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_pair"}, obs_q[i], exp_q[i]);
        check_eq({tag, "_ferr_count"}, obs_ferr, exp_ferr);
        obs_q.delete();
        exp_q.delete();
        obs_ferr = 0;
        exp_ferr = 0;
    endtask

    initial begin
        logic [SW-1:0] pl[3];
        logic [SW-1:0] pr[3];
        logic [SW-1:0] w;
        int            sel;
        int            n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_left",      left_sample,  16'h0000);
        check_eq("rst_right",     right_sample, 16'h0000);
        check_eq("rst_valid",     sample_valid, 1'b0);
        check_eq("rst_overrun",   overrun,      1'b0);
        check_eq("rst_frame_err", frame_err,    1'b0);
        rst = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);

        // Basic pair with ready held high
        send_half(1'b0, 32, 16'($urandom), -1);
        send_half(1'b1, 32, 16'($urandom), -1);
        send_pair(16'hA5C3, 16'h7FFF);
        checkpoint("basic");
        check_eq("basic_overrun", overrun, 1'b0);
        check_eq("basic_valid_clear", sample_valid, 1'b0);

        // Stimulus resumes mid-right-word after reset
        do_reset(1'b1);
        send_half(1'b1, 12, 16'($urandom), -1);
        send_pair(16'h8000, 16'h0001);
        checkpoint("midword");

        // Short left half raises frame_err and breaks that frame's pair
        send_half(1'b0, 10, 16'($urandom), -1);
        send_half(1'b1, 32, 16'($urandom), -1);
        send_pair(16'($urandom), 16'($urandom));
        checkpoint("short_left");

        // Pair completes on the same cycle the held pair is accepted
        sample_ready = 1'b0;
        send_pair(16'h1234, 16'h5678);
        send_half(1'b0, 32, 16'h9ABC, -1);
        send_half(1'b1, 32, 16'hDEF0, SW);
        check_eq("coinc_valid",   sample_valid, 1'b1);
        check_eq("coinc_overrun", overrun,      1'b0);
        check_eq("coinc_left",    left_sample,  16'h9ABC);
        check_eq("coinc_right",   right_sample, 16'hDEF0);
        sample_ready = 1'b1;
        checkpoint("coinc");

        // Three unconsumed pairs: only the latest survives, overrun is sticky
        sample_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pl[k] = 16'($urandom) ^ 16'(k);
            pr[k] = 16'($urandom) ^ 16'(k << 4);
            send_pair(pl[k], pr[k]);
            check_eq("ovr_flag", overrun, (k >= 1) ? 1'b1 : 1'b0);
        end
        check_eq("ovr_valid", sample_valid, 1'b1);
        check_eq("ovr_left",  left_sample,  pl[2]);
        check_eq("ovr_right", right_sample, pr[2]);
        while (exp_q.size() > 1) exp_q.delete(0);
        @(posedge clk); #1 sample_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("ovr_valid_drop", sample_valid, 1'b0);
        check_eq("ovr_sticky",     overrun,      1'b1);
        checkpoint("overrun");

        // Asynchronous reset in the middle of a word
        send_half(1'b0, 10, 16'($urandom), -1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_left",    left_sample,  16'h0000);
        check_eq("midrst_right",   right_sample, 16'h0000);
        check_eq("midrst_valid",   sample_valid, 1'b0);
        check_eq("midrst_overrun", overrun,      1'b0);
        check_eq("midrst_ferr",    frame_err,    1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        send_half(1'b0, 32, 16'($urandom), -1);
        send_half(1'b1, 32, 16'($urandom), -1);
        send_pair(16'($urandom), 16'($urandom));
        checkpoint("midrst");

        // Random half lengths (short, exactly enough, full) and random words
        for (int h = 0; h < 14; h++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      n = $urandom_range(2, SW);
            else if (sel == 1) n = SW + 1;
            else               n = 32;
            w = 16'($urandom);
            send_half(1'((h % 2)), n, w, -1);
        end
        send_half(1'b0, 32, 16'($urandom), -1);
        checkpoint("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
